// File: rtl/bp_mc_rx_bridge_pkg.sv
// Shared types for the manycore -> BlackParrot RX bridge.
// Holds the local model of BP's uncached memory command/response message,
// the bridge FSM states, and the store-mask decode helper.
package bp_mc_rx_pkg;

    localparam int paddr_width_gp    = 40;
    localparam int cce_data_width_gp = 64;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_size_1 = 3'd0,
        e_mem_size_2 = 3'd1,
        e_mem_size_4 = 3'd2,
        e_mem_size_8 = 3'd3
    } bp_mem_size_e;

    // Store data sits in the low bytes of data, already shifted down to bit 0.
    // payload stands in for the remaining header fields, which this bridge leaves 0.
    typedef struct packed {
        bp_cce_mem_cmd_type_e        msg_type;
        bp_mem_size_e                size;
        logic [paddr_width_gp-1:0]   addr;
        logic [15:0]                 payload;
        logic [cce_data_width_gp-1:0] data;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, ACK, RET} state_e;

    typedef struct packed {
        bp_mem_size_e size;
        logic [1:0]   offset;
        logic         illegal;
    } mask_dec_s;

    // Only naturally aligned byte, half and word masks map to a BP access;
    // everything else falls back to a full word and is flagged.
    function automatic mask_dec_s mask_to_size(input logic [3:0] mask);
        mask_dec_s r;
        r.size    = e_mem_size_4;
        r.offset  = 2'd0;
        r.illegal = 1'b0;
        case (mask)
            4'b0001: begin r.size = e_mem_size_1; r.offset = 2'd0; end
            4'b0010: begin r.size = e_mem_size_1; r.offset = 2'd1; end
            4'b0100: begin r.size = e_mem_size_1; r.offset = 2'd2; end
            4'b1000: begin r.size = e_mem_size_1; r.offset = 2'd3; end
            4'b0011: begin r.size = e_mem_size_2; r.offset = 2'd0; end
            4'b1100: begin r.size = e_mem_size_2; r.offset = 2'd2; end
            4'b1111: r.size = e_mem_size_4;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bp_mc_rx_bridge_if.sv
// Request/response bus of the RX bridge: endpoint in_request group on one
// side, BP uncached I/O command/response on the other.
// slave = the bridge itself, master = the endpoint + BP environment.
interface bp_mc_rx_bridge_if #(
    parameter int mc_data_width_p = 32,
    parameter int mc_addr_width_p = 28
);
    import bp_mc_rx_pkg::*;

    logic                         in_v_i;
    logic [mc_data_width_p-1:0]   in_data_i;
    logic [mc_data_width_p/8-1:0] in_mask_i;
    logic [mc_addr_width_p-1:0]   in_addr_i;
    logic                         in_we_i;
    logic                         in_yumi_o;
    logic [mc_data_width_p-1:0]   returning_data_o;
    logic                         returning_v_o;
    bp_cce_mem_msg_s              io_cmd_o;
    logic                         io_cmd_v_o;
    logic                         io_cmd_yumi_i;
    bp_cce_mem_msg_s              io_resp_i;
    logic                         io_resp_v_i;
    logic                         io_resp_yumi_o;
    logic                         error_o;

    modport slave (
        input  in_v_i, in_data_i, in_mask_i, in_addr_i, in_we_i,
        input  io_cmd_yumi_i, io_resp_i, io_resp_v_i,
        output in_yumi_o, returning_data_o, returning_v_o,
        output io_cmd_o, io_cmd_v_o, io_resp_yumi_o, error_o
    );

    modport master (
        output in_v_i, in_data_i, in_mask_i, in_addr_i, in_we_i,
        output io_cmd_yumi_i, io_resp_i, io_resp_v_i,
        input  in_yumi_o, returning_data_o, returning_v_o,
        input  io_cmd_o, io_cmd_v_o, io_resp_yumi_o, error_o
    );

endinterface

// File: rtl/bp_mc_rx_bridge_mask_decode.sv
// Combinational store byte-mask decode: mask -> BP access size, byte offset
// within the word, and an illegal-mask flag.
module bp_mc_rx_mask_decode
    import bp_mc_rx_pkg::*;
(
    input  logic [3:0] mask,
    output mask_dec_s  dec
);

    // Pure table lookup, shared with the package helper
    always_comb begin
        dec = mask_to_size(mask);
    end

endmodule

// File: rtl/bp_mc_rx_bridge.sv
// Manycore -> BlackParrot RX bridge. Turns each endpoint remote load/store
// into one uncached BP I/O command, waits for BP's response, then acks the
// endpoint and returns the data one cycle later. One request in flight.
// Optional feature: define BP_MC_RX_ADDR_CHECK_EN to reject word addresses
// at or above win_words_p without touching BP (returns 0, sets error_o).
module bp_mc_rx_bridge
    import bp_mc_rx_pkg::*;
#(
    parameter int                        mc_data_width_p = 32,
    parameter int                        mc_addr_width_p = 28,
    parameter logic [paddr_width_gp-1:0] base_paddr_p    = '0
`ifdef BP_MC_RX_ADDR_CHECK_EN
   ,parameter int                        win_words_p     = 2**20
`endif
)(
    input  logic           clk_i,
    input  logic           reset_n_i,
    bp_mc_rx_bridge_if.slave bus
);

    state_e                     state_r, state_n;
    bp_cce_mem_msg_s            cmd_r, cmd_n;
    logic [mc_data_width_p-1:0] resp_word_r, resp_word_n;
    logic                       error_r, error_n;

    mask_dec_s                  dec;
    bp_cce_mem_msg_s            req_cmd;
    logic                       req_illegal;
    logic [1:0]                 req_offset;
    logic [cce_data_width_gp-1:0] lane_data;
    logic                       out_of_win;

    // Only the low data word of a BP response is ever returned to the manycore
    logic unused_resp;
    assign unused_resp = ^bus.io_resp_i[cce_mem_msg_width_lp-1:mc_data_width_p];

    bp_mc_rx_mask_decode u_mask_decode (
        .mask (bus.in_mask_i[3:0]),
        .dec  (dec)
    );

`ifdef BP_MC_RX_ADDR_CHECK_EN
    assign out_of_win = (64'(bus.in_addr_i) >= 64'(win_words_p));
`else
    assign out_of_win = 1'b0;
`endif

    // Build the BP command for the request currently presented by the endpoint
    always_comb begin
        req_cmd     = '0;
        req_illegal = 1'b0;
        req_offset  = 2'd0;
        lane_data   = 64'(bus.in_data_i) >> {dec.offset, 3'b000};
        if (bus.in_we_i) begin
            req_cmd.msg_type = e_cce_mem_uc_wr;
            req_cmd.size     = dec.size;
            req_illegal      = dec.illegal;
            req_offset       = dec.offset;
            case (dec.size)
                e_mem_size_1: req_cmd.data = {56'd0, lane_data[7:0]};
                e_mem_size_2: req_cmd.data = {48'd0, lane_data[15:0]};
                default:      req_cmd.data = 64'(bus.in_data_i);
            endcase
        end else begin
            req_cmd.msg_type = e_cce_mem_uc_rd;
            req_cmd.size     = e_mem_size_4;
        end
        // Wraps silently in paddr width
        req_cmd.addr = base_paddr_p
                     + paddr_width_gp'({bus.in_addr_i, 2'b00})
                     + paddr_width_gp'(req_offset);
    end

    // State, command, response word and sticky error registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            cmd_r       <= '0;
            resp_word_r <= '0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            cmd_r       <= cmd_n;
            resp_word_r <= resp_word_n;
            error_r     <= error_n;
        end
    end

    // Next state and handshake outputs; endpoint is acked only after BP answers
    always_comb begin
        state_n              = state_r;
        cmd_n                = cmd_r;
        resp_word_n          = resp_word_r;
        error_n              = error_r;
        bus.in_yumi_o        = 1'b0;
        bus.returning_v_o    = 1'b0;
        bus.returning_data_o = '0;
        bus.io_cmd_v_o       = 1'b0;
        bus.io_resp_yumi_o   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_v_i) begin
                    if (out_of_win) begin
                        resp_word_n = '0;
                        error_n     = 1'b1;
                        state_n     = ACK;
                    end else begin
                        cmd_n   = req_cmd;
                        error_n = error_r | req_illegal;
                        state_n = SEND;
                    end
                end
            end
            SEND: begin
                bus.io_cmd_v_o = 1'b1;
                if (bus.io_cmd_yumi_i) state_n = WAIT;
            end
            WAIT: begin
                bus.io_resp_yumi_o = bus.io_resp_v_i;
                if (bus.io_resp_v_i) begin
                    resp_word_n = (cmd_r.msg_type == e_cce_mem_uc_wr)
                                ? '0 : bus.io_resp_i.data[mc_data_width_p-1:0];
                    state_n     = ACK;
                end
            end
            ACK: begin
                bus.in_yumi_o = 1'b1;
                state_n       = RET;
            end
            RET: begin
                bus.returning_v_o    = 1'b1;
                bus.returning_data_o = resp_word_r;
                state_n              = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.io_cmd_o = cmd_r;
    assign bus.error_o  = error_r;

endmodule

// File: tb/tb_bp_mc_rx_bridge.sv
// Self-checking bench for bp_mc_rx_bridge: directed cases followed by random
// transactions checked against a byte-level reference model.
module tb_bp_mc_rx_bridge;
    import bp_mc_rx_pkg::*;

    localparam logic [paddr_width_gp-1:0] BASE = '0;
`ifdef BP_MC_RX_ADDR_CHECK_EN
    localparam bit CHK_EN = 1'b1;
    localparam int WIN    = 16;
`else
    localparam bit CHK_EN = 1'b0;
    localparam int WIN    = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_mc_rx_bridge_if #(.mc_data_width_p(32), .mc_addr_width_p(28)) bus ();

    bp_mc_rx_bridge #(
        .mc_data_width_p (32),
        .mc_addr_width_p (28),
        .base_paddr_p    (BASE)
`ifdef BP_MC_RX_ADDR_CHECK_EN
       ,.win_words_p     (WIN)
`endif
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    logic            err_model = 1'b0;
    bp_cce_mem_msg_s last_cmd;
    logic [31:0]     last_ret;
    logic [3:0]      legal_masks [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                         4'b0011, 4'b1100, 4'b1111};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a store touches $countones(mask) bytes starting at the lowest set lane
    function automatic void model_cmd(input logic we, input logic [3:0] mask,
                                      input logic [31:0] data, input logic [27:0] addr,
                                      output bp_cce_mem_msg_s c, output logic ill);
        int nbytes, off;
        logic [63:0] d;
        c = '0;
        ill = 1'b0;
        nbytes = 4;
        off = 0;
        if (we) begin
            if (mask inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}) begin
                nbytes = $countones(mask);
                for (int b = 3; b >= 0; b--) if (mask[b]) off = b;
            end else begin
                ill = 1'b1;
            end
        end
        d = {32'd0, data} >> (8 * off);
        if (nbytes < 4) d = d & ((64'd1 << (8 * nbytes)) - 64'd1);
        c.msg_type = we ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
        c.size     = (nbytes == 1) ? e_mem_size_1 : (nbytes == 2) ? e_mem_size_2 : e_mem_size_4;
        c.addr     = BASE + 40'(addr) * 40'd4 + 40'(off);
        c.data     = we ? d : 64'd0;
    endfunction

    function automatic logic [27:0] rand_addr();
        return ($urandom_range(0, 1) == 1) ? 28'($urandom_range(0, 31)) : 28'($urandom);
    endfunction

    // Full transaction, entered and left at a falling edge with the DUT idle
    task automatic do_txn(input logic we, input logic [3:0] mask, input logic [31:0] data,
                          input logic [27:0] addr, input int cmd_dly, input int resp_dly,
                          input logic [63:0] resp_data);
        bp_cce_mem_msg_s exp_cmd;
        logic ill, oow;
        logic [31:0] exp_ret;
        model_cmd(we, mask, data, addr, exp_cmd, ill);
        oow = CHK_EN && (32'(addr) >= 32'(WIN));
        exp_ret = (we || oow) ? 32'd0 : resp_data[31:0];
        bus.in_v_i = 1'b1; bus.in_we_i = we; bus.in_mask_i = mask;
        bus.in_data_i = data; bus.in_addr_i = addr;
        @(negedge clk);
        if (oow) begin
            chk("oow.cmd_v", bus.io_cmd_v_o, 1'b0);
            chk("oow.in_yumi", bus.in_yumi_o, 1'b1);
            @(negedge clk);
        end else begin
            chk("send.cmd_v", bus.io_cmd_v_o, 1'b1);
            chk("send.cmd", bus.io_cmd_o, exp_cmd);
            chk("send.in_yumi", bus.in_yumi_o, 1'b0);
            last_cmd = bus.io_cmd_o;
            for (int i = 0; i < cmd_dly; i++) begin
                bus.io_resp_v_i = 1'b1;
                #1 chk("send.stray_yumi", bus.io_resp_yumi_o, 1'b0);
                @(negedge clk);
                chk("send.hold_cmd", bus.io_cmd_o, exp_cmd);
                chk("send.hold_v", bus.io_cmd_v_o, 1'b1);
                chk("send.hold_in_yumi", bus.in_yumi_o, 1'b0);
            end
            bus.io_resp_v_i = 1'b0;
            bus.io_cmd_yumi_i = 1'b1;
            @(negedge clk);
            bus.io_cmd_yumi_i = 1'b0;
            chk("wait.cmd_v", bus.io_cmd_v_o, 1'b0);
            for (int i = 0; i < resp_dly; i++) begin
                chk("wait.in_yumi", bus.in_yumi_o, 1'b0);
                @(negedge clk);
            end
            bus.io_resp_i = '0;
            bus.io_resp_i.msg_type = we ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
            bus.io_resp_i.data = resp_data;
            bus.io_resp_v_i = 1'b1;
            #1 chk("wait.resp_yumi", bus.io_resp_yumi_o, 1'b1);
            @(negedge clk);
            bus.io_resp_v_i = 1'b0;
            chk("ack.in_yumi", bus.in_yumi_o, 1'b1);
            chk("ack.ret_v", bus.returning_v_o, 1'b0);
            @(negedge clk);
        end
        bus.in_v_i = 1'b0;
        chk("ret.in_yumi", bus.in_yumi_o, 1'b0);
        chk("ret.v", bus.returning_v_o, 1'b1);
        chk("ret.data", bus.returning_data_o, exp_ret);
        last_ret = bus.returning_data_o;
        @(negedge clk);
        chk("idle.ret_v", bus.returning_v_o, 1'b0);
        chk("idle.cmd_v", bus.io_cmd_v_o, 1'b0);
        err_model = err_model | ill | oow;
        chk("error", bus.error_o, err_model);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".in_yumi"}, bus.in_yumi_o, 1'b0);
        chk({tag, ".ret_v"}, bus.returning_v_o, 1'b0);
        chk({tag, ".ret_data"}, bus.returning_data_o, 32'd0);
        chk({tag, ".cmd"}, bus.io_cmd_o, 127'd0);
        chk({tag, ".cmd_v"}, bus.io_cmd_v_o, 1'b0);
        chk({tag, ".resp_yumi"}, bus.io_resp_yumi_o, 1'b0);
        chk({tag, ".error"}, bus.error_o, 1'b0);
    endtask

    initial begin
        logic we;
        logic [3:0] mask;
        bus.in_v_i = 1'b0; bus.in_we_i = 1'b0; bus.in_mask_i = '0;
        bus.in_data_i = '0; bus.in_addr_i = '0;
        bus.io_cmd_yumi_i = 1'b0; bus.io_resp_v_i = 1'b0; bus.io_resp_i = '0;

        // Reset state
        #1 chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Load word 0x10 -> uc_rd paddr 0x40 size_4
        do_txn(1'b0, 4'hF, 32'd0, 28'h10, 0, 0, {32'h1111_2222, 32'hCAFE_F00D});
        chk("ld.addr", last_cmd.addr, 40'h40);
        chk("ld.size", last_cmd.size, e_mem_size_4);
        chk("ld.type", last_cmd.msg_type, e_cce_mem_uc_rd);
        chk("ld.ret", last_ret, 32'hCAFE_F00D);

        // Byte store lane 2 -> paddr 0xE, byte 0xBB
        do_txn(1'b1, 4'b0100, 32'hAABB_CCDD, 28'h3, 1, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("st.addr", last_cmd.addr, 40'hE);
        chk("st.size", last_cmd.size, e_mem_size_1);
        chk("st.data", last_cmd.data, 64'hBB);
        chk("st.ret", last_ret, 32'd0);
        chk("st.error", bus.error_o, 1'b0);

        // BP stalls command acceptance for 10 cycles, with stray responses
        do_txn(1'b0, 4'hF, 32'd0, 28'h7, 10, 1, {$urandom, $urandom});

        // Random legal traffic
        for (int t = 0; t < 20; t++) begin
            we = 1'($urandom_range(0, 1));
            mask = legal_masks[$urandom_range(0, 6)];
            do_txn(we, mask, $urandom, rand_addr(), $urandom_range(0, 3),
                   $urandom_range(0, 3), {$urandom, $urandom});
        end

        // Illegal mask: full-word write, error becomes sticky
        do_txn(1'b1, 4'b0101, 32'h1234_5678, 28'h1, 0, 0, 64'd0);
        chk("bad.size", last_cmd.size, e_mem_size_4);
        chk("bad.data", last_cmd.data, 64'h1234_5678);
        chk("bad.error", bus.error_o, 1'b1);

        // Random traffic including illegal masks
        for (int t = 0; t < 20; t++) begin
            we = 1'($urandom_range(0, 1));
            mask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : legal_masks[$urandom_range(0, 6)];
            do_txn(we, mask, $urandom, rand_addr(), $urandom_range(0, 3),
                   $urandom_range(0, 3), {$urandom, $urandom});
        end

        // Reset while waiting on BP
        bus.in_v_i = 1'b1; bus.in_we_i = 1'b0; bus.in_mask_i = 4'hF;
        bus.in_data_i = '0; bus.in_addr_i = 28'h5;
        @(negedge clk);
        bus.io_cmd_yumi_i = 1'b1;
        @(negedge clk);
        bus.io_cmd_yumi_i = 1'b0;
        bus.io_resp_i = '0;
        bus.io_resp_v_i = 1'b1;
        #1 chk("rst.pre_yumi", bus.io_resp_yumi_o, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        bus.io_resp_v_i = 1'b0;
        bus.in_v_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        err_model = 1'b0;
        @(negedge clk);
        do_txn(1'b0, 4'hF, 32'd0, 28'h2, 0, 0, {32'h1234_5678, 32'h9ABC_DEF0});
        chk("post_rst.ret", last_ret, 32'h9ABC_DEF0);

`ifdef BP_MC_RX_ADDR_CHECK_EN
        // Out-of-window access never reaches BP
        do_txn(1'b0, 4'hF, 32'd0, 28'h20, 0, 0, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("oow.ret", last_ret, 32'd0);
        chk("oow.error", bus.error_o, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
